// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types, widths and helpers for the serial 4-to-2 encoder
package enc_pkg;

    localparam int N_IN   = 4;
    localparam int CODE_W = $clog2(N_IN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/enc4x2_serial_if.sv
// rtl/enc4x2_serial_if.sv - request-in / code-out handshake bundle for the encoder
interface enc4x2_serial_if;
    import enc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_d;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              err_zero;

    modport master (
        output in_valid, in_d, out_ready,
        input  in_ready, out_valid, out_code, out_last, err_zero
    );

    modport slave (
        input  in_valid, in_d, out_ready,
        output in_ready, out_valid, out_code, out_last, err_zero
    );

endinterface

// File: rtl/pri_enc4.sv
// rtl/pri_enc4.sv - combinational 4-input priority encoder, direction chosen by PRIO_LSB
module pri_enc4 #(
    parameter bit PRIO_LSB = 1'b1
) (
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       found
);

    // The last match written wins, so scan from the opposite end of the priority.
    always_comb begin
        idx   = 2'd0;
        found = |vec;
        if (PRIO_LSB) begin
            for (int i = 3; i >= 0; i--) begin
                if (vec[i]) idx = 2'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vec[i]) idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/enc4x2_serial.sv
// rtl/enc4x2_serial.sv - accepts a multi-hot request vector and emits each set index serially
module enc4x2_serial #(
    parameter int N_IN     = 4,
    parameter int CODE_W   = 2,
    parameter bit PRIO_LSB = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    enc4x2_serial_if.slave  bus
);
    import enc_pkg::*;

    state_t            state;
    logic [N_IN-1:0]   pend;
    logic [CODE_W-1:0] idx;
    logic              found;
    logic              last;
    logic              err_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              in_zero;

    pri_enc4 #(.PRIO_LSB(PRIO_LSB)) u_pri (
        .vec   (pend),
        .idx   (idx),
        .found (found)
    );

    assign last     = (state == BUSY) && (popcount4(pend) == 3'd1);
    assign in_zero  = (bus.in_d == '0);

    // rst_n gates in_ready so nothing is accepted while the block is held in reset.
    assign bus.in_ready = rst_n && ((state == IDLE) || (last && bus.out_ready));
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = bus.out_valid && bus.out_ready;

    assign bus.out_valid = (state == BUSY);
    assign bus.out_code  = found ? idx : '0;
    assign bus.out_last  = last;
    assign bus.err_zero  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= in_xfer && in_zero;
            case (state)
                IDLE: begin
                    if (in_xfer && !in_zero) begin
                        pend  <= bus.in_d;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_xfer) begin
                        if (last) begin
                            // A vector arriving on the final beat reloads without an idle bubble.
                            if (in_xfer && !in_zero) begin
                                pend <= bus.in_d;
                            end else begin
                                pend  <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            pend[idx] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc4x2_serial.sv
// tb/tb_enc4x2_serial.sv - table, directed and random checks of both priority orders
module tb_enc4x2_serial;

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic       ev;
        logic [1:0] cl;
        logic [1:0] cm;
        logic       el;
        logic       er;
        logic       ee;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    enc4x2_serial_if ifl ();
    enc4x2_serial_if ifm ();

    enc4x2_serial #(.N_IN(4), .CODE_W(2), .PRIO_LSB(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ifl));
    enc4x2_serial #(.N_IN(4), .CODE_W(2), .PRIO_LSB(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ifm));

    // Reference: each accepted vector becomes a list of codes in emission order.
    int q_l[$];
    int q_m[$];
    bit err_pend;

    logic       s_vl, s_vm, s_ll, s_lm, s_rl, s_rm, s_el, s_em;
    logic [1:0] s_cl, s_cm;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        ifl.in_valid = v; ifl.in_d = d; ifl.out_ready = r;
        ifm.in_valid = v; ifm.in_d = d; ifm.out_ready = r;
    endtask

    task automatic model_check(input logic r);
        int  n;
        bit  ev;
        n  = q_l.size();
        ev = (n != 0);
        chk("model valid lsb", int'(ifl.out_valid), int'(ev));
        chk("model valid msb", int'(ifm.out_valid), int'(ev));
        if (ev) begin
            chk("model code lsb", int'(ifl.out_code), q_l[0]);
            chk("model code msb", int'(ifm.out_code), q_m[0]);
            chk("model last lsb", int'(ifl.out_last), int'(n == 1));
            chk("model last msb", int'(ifm.out_last), int'(n == 1));
        end
        chk("model ready lsb", int'(ifl.in_ready), int'(n == 0 || (n == 1 && r)));
        chk("model ready msb", int'(ifm.in_ready), int'(n == 0 || (n == 1 && r)));
        chk("model err lsb", int'(ifl.err_zero), int'(err_pend));
        chk("model err msb", int'(ifm.err_zero), int'(err_pend));
    endtask

    task automatic model_update(input logic v, input logic [3:0] d, input logic r);
        int  n;
        bit  rdy;
        n   = q_l.size();
        rdy = (n == 0) || (n == 1 && r);
        if (n != 0 && r) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
        end
        err_pend = 1'b0;
        if (v && rdy) begin
            if (d == 4'b0000) err_pend = 1'b1;
            for (int i = 0; i < 4; i++) if (d[i]) q_l.push_back(i);
            for (int i = 3; i >= 0; i--) if (d[i]) q_m.push_back(i);
        end
    endtask

    // Called just after a rising edge; samples on the falling edge, returns just after the next rising edge.
    task automatic step(input logic v, input logic [3:0] d, input logic r);
        drive(v, d, r);
        @(negedge clk);
        s_vl = ifl.out_valid; s_vm = ifm.out_valid;
        s_cl = ifl.out_code;  s_cm = ifm.out_code;
        s_ll = ifl.out_last;  s_lm = ifm.out_last;
        s_rl = ifl.in_ready;  s_rm = ifm.in_ready;
        s_el = ifl.err_zero;  s_em = ifm.err_zero;
        model_check(r);
        model_update(v, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid lsb"}, int'(ifl.out_valid), 0);
        chk({tag, " valid msb"}, int'(ifm.out_valid), 0);
        chk({tag, " code lsb"},  int'(ifl.out_code), 0);
        chk({tag, " code msb"},  int'(ifm.out_code), 0);
        chk({tag, " last lsb"},  int'(ifl.out_last), 0);
        chk({tag, " err lsb"},   int'(ifl.err_zero), 0);
        chk({tag, " ready lsb"}, int'(ifl.in_ready), 0);
        chk({tag, " ready msb"}, int'(ifm.in_ready), 0);
    endtask

    function automatic row_t mk(logic iv, logic [3:0] d, logic o, logic ev, logic [1:0] cl,
                                logic [1:0] cm, logic el, logic er, logic ee);
        row_t t;
        t.iv = iv; t.d = d; t.ordy = o; t.ev = ev; t.cl = cl; t.cm = cm;
        t.el = el; t.er = er; t.ee = ee;
        return t;
    endfunction

    row_t rows[26];

    initial begin
        rows[0]  = mk(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[1]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
        rows[2]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[3]  = mk(1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[4]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        rows[5]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        rows[6]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
        rows[7]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[8]  = mk(1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[9]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        rows[10] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        rows[11] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        rows[12] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        rows[13] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
        rows[14] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[15] = mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[16] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        rows[17] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[18] = mk(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[19] = mk(1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        rows[20] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
        rows[21] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[22] = mk(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        rows[23] = mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
        rows[24] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        rows[25] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

        err_pend = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (rows[i]) begin
            step(rows[i].iv, rows[i].d, rows[i].ordy);
            chk($sformatf("row%0d valid lsb", i), int'(s_vl), int'(rows[i].ev));
            chk($sformatf("row%0d valid msb", i), int'(s_vm), int'(rows[i].ev));
            if (rows[i].ev) begin
                chk($sformatf("row%0d code lsb", i), int'(s_cl), int'(rows[i].cl));
                chk($sformatf("row%0d code msb", i), int'(s_cm), int'(rows[i].cm));
                chk($sformatf("row%0d last lsb", i), int'(s_ll), int'(rows[i].el));
                chk($sformatf("row%0d last msb", i), int'(s_lm), int'(rows[i].el));
            end
            chk($sformatf("row%0d ready lsb", i), int'(s_rl), int'(rows[i].er));
            chk($sformatf("row%0d ready msb", i), int'(s_rm), int'(rows[i].er));
            chk($sformatf("row%0d err lsb", i), int'(s_el), int'(rows[i].ee));
            chk($sformatf("row%0d err msb", i), int'(s_em), int'(rows[i].ee));
        end

        // Reset in the middle of 4'b1110: outputs clear without waiting for a clock edge.
        step(1'b1, 4'b1110, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        drive(1'b0, 4'b0000, 1'b1);
        #2;
        chk("midrun valid before reset", int'(ifl.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        q_l.delete();
        q_m.delete();
        err_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 4'b0000, 1'b1);
        chk("post reset ready", int'(s_rl), 1);
        chk("post reset no stale code", int'(s_vl), 0);
        step(1'b0, 4'b0000, 1'b1);
        chk("post reset still idle", int'(s_vm), 0);

        for (int n = 0; n < 400; n++) begin
            logic       v, r;
            logic [3:0] d;
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step(v, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
